// File: rtl/snake_game_ctrl_if.sv
// Handshake bundle between the movement stage and snake_game_ctrl.
// master: movement/test side drives strobes and candidate array; slave: the controller.
interface snake_game_ctrl_if #(
   parameter int MAX_LEN = 16,
   parameter int NUM_LEN = 10
);
   localparam int LW = $clog2(MAX_LEN);

   logic                       tick;
   logic                       start;
   logic                       should_stop;
   logic [MAX_LEN*NUM_LEN-1:0] next_pos_num;
   logic [MAX_LEN*NUM_LEN-1:0] pos_num;
   logic [LW-1:0]              len;
   logic [NUM_LEN-1:0]         food_pos;
   logic [7:0]                 score;
   logic                       game_over;
   logic                       busy;

   modport master (
      output tick, start, should_stop, next_pos_num,
      input  pos_num, len, food_pos, score, game_over, busy
   );

   modport slave (
      input  tick, start, should_stop, next_pos_num,
      output pos_num, len, food_pos, score, game_over, busy
   );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game controller: registers the segment array per tick, owns len/food/score
// and the IDLE/RUN/CHECK/FOOD/OVER FSM; places food with a 10-bit LFSR.
// Ports: clk, rst_n (async active-low), bus (slave modport): tick, start,
//   should_stop, next_pos_num in; pos_num, len, food_pos, score, game_over, busy out.
// Optional: define SNAKE_SELF_HIT_EN to enable the body self-collision scan in CHECK.
module snake_game_ctrl #(
   parameter int                MAX_LEN   = 16,
   parameter int                NUM_LEN   = 10,
   parameter int                INIT_LEN  = 4,
   parameter logic [NUM_LEN-1:0] INIT_HEAD = 10'd165,
   parameter logic [NUM_LEN-1:0] FOOD_INIT = 10'd180,
   parameter logic [9:0]        LFSR_SEED = 10'h2A5
) (
   input logic               clk,
   input logic               rst_n,
   snake_game_ctrl_if.slave  bus
);
   localparam int W  = MAX_LEN * NUM_LEN;
   localparam int LW = $clog2(MAX_LEN);
   localparam logic [NUM_LEN-1:0] CELLS   = NUM_LEN'(768);
   localparam logic [LW-1:0]      LEN_MAX = LW'(MAX_LEN - 1);
   localparam logic [LW-1:0]      LEN_RST = LW'(INIT_LEN);

   function automatic logic [W-1:0] init_pos();
      logic [W-1:0] v;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (i < INIT_LEN)
            v[i*NUM_LEN +: NUM_LEN] = INIT_HEAD - NUM_LEN'(i);
         else
            v[i*NUM_LEN +: NUM_LEN] = '1;
      end
      return v;
   endfunction

   localparam logic [W-1:0] POS_INIT = init_pos();

   typedef enum logic [2:0] {
      S_IDLE, S_RUN, S_CHECK, S_FOOD, S_OVER
   } state_t;

   state_t             state_q, state_d;
   logic [W-1:0]       pos_q, pos_d;
   logic [LW-1:0]      len_q, len_d;
   logic [NUM_LEN-1:0] food_q, food_d;
   logic [7:0]         score_q, score_d;
   logic [9:0]         lfsr_q, lfsr_d;
   logic [NUM_LEN-1:0] cand_q, cand_d;
   logic [LW-1:0]      fidx_q, fidx_d;
`ifdef SNAKE_SELF_HIT_EN
   logic [LW-1:0]      idx_q, idx_d;
`endif

   logic [NUM_LEN-1:0] head;
   logic               scan_done;

   assign head = pos_q[NUM_LEN-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pos_q   <= POS_INIT;
         len_q   <= LEN_RST;
         food_q  <= FOOD_INIT;
         score_q <= '0;
         lfsr_q  <= LFSR_SEED;
         cand_q  <= '0;
         fidx_q  <= '0;
`ifdef SNAKE_SELF_HIT_EN
         idx_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         len_q   <= len_d;
         food_q  <= food_d;
         score_q <= score_d;
         lfsr_q  <= lfsr_d;
         cand_q  <= cand_d;
         fidx_q  <= fidx_d;
`ifdef SNAKE_SELF_HIT_EN
         idx_q   <= idx_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      len_d     = len_q;
      food_d    = food_q;
      score_d   = score_q;
      cand_d    = cand_q;
      fidx_d    = fidx_q;
      scan_done = 1'b0;
`ifdef SNAKE_SELF_HIT_EN
      idx_d     = idx_q;
`endif
      // free-running, x^10+x^7+1
      lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

      unique case (state_q)
         S_IDLE: begin
            if (bus.start)
               state_d = S_RUN;
         end
         S_RUN: begin
            if (bus.tick) begin
               if (bus.should_stop) begin
                  state_d = S_OVER;
               end else begin
                  pos_d   = bus.next_pos_num;
                  state_d = S_CHECK;
`ifdef SNAKE_SELF_HIT_EN
                  idx_d   = LW'(1);
`endif
               end
            end
         end
         S_CHECK: begin
`ifdef SNAKE_SELF_HIT_EN
            // one body slot per cycle, then the food compare
            if (idx_q < len_q) begin
               if (pos_q[idx_q*NUM_LEN +: NUM_LEN] == head)
                  state_d = S_OVER;
               else
                  idx_d = idx_q + 1'b1;
            end else begin
               scan_done = 1'b1;
            end
`else
            scan_done = 1'b1;
`endif
            if (scan_done) begin
               if (head == food_q) begin
                  if (len_q != LEN_MAX)
                     len_d = len_q + 1'b1;
                  if (score_q != 8'hFF)
                     score_d = score_q + 8'd1;
                  cand_d  = NUM_LEN'(lfsr_q);
                  fidx_d  = '0;
                  state_d = S_FOOD;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_FOOD: begin
            // off-grid or body hit: take a fresh sample, restart scan
            if (cand_q >= CELLS) begin
               cand_d = NUM_LEN'(lfsr_q);
               fidx_d = '0;
            end else if (fidx_q < len_q) begin
               if (pos_q[fidx_q*NUM_LEN +: NUM_LEN] == cand_q) begin
                  cand_d = NUM_LEN'(lfsr_q);
                  fidx_d = '0;
               end else begin
                  fidx_d = fidx_q + 1'b1;
               end
            end else begin
               food_d  = cand_q;
               state_d = S_RUN;
            end
         end
         S_OVER: begin
            if (bus.start) begin
               pos_d   = POS_INIT;
               len_d   = LEN_RST;
               food_d  = FOOD_INIT;
               score_d = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.pos_num   = pos_q;
   assign bus.len       = len_q;
   assign bus.food_pos  = food_q;
   assign bus.score     = score_q;
   assign bus.game_over = (state_q == S_OVER);
   assign bus.busy      = (state_q == S_CHECK) || (state_q == S_FOOD);

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl: a behavioural snake model predicts each
// event's outcome; a negedge monitor pops and compares once busy has dropped.
module tb_snake_game_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic probe = 1'b0;

   always #5 clk = ~clk;

   snake_game_ctrl_if bus ();

   snake_game_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [159:0] pos;
      int           len;
      int           score;
      bit           over;
      bit           food_known;
      int           food;
      int           bmin;
      int           bmax;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;
   int   issued = 0;
   int   done_cnt = 0;

   int   m_pos[16];
   int   m_len, m_score, m_food, m_mode; // mode: 0 idle, 1 run, 2 over
   bit   hit_en;

   task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [159:0] pack(input int p[16]);
      logic [159:0] v;
      for (int i = 0; i < 16; i++) v[i*10 +: 10] = 10'(p[i]);
      return v;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) m_pos[i] = (i < 4) ? 165 - i : 1023;
      m_len = 4; m_food = 180; m_score = 0; m_mode = 0;
   endfunction

   function automatic exp_t cur_exp();
      exp_t e;
      e.pos = pack(m_pos); e.len = m_len; e.score = m_score;
      e.over = (m_mode == 2); e.food_known = 1'b1; e.food = m_food;
      e.bmin = 0; e.bmax = 0;
      return e;
   endfunction

   // monitor
   initial begin
      bit   pend;
      int   bcnt;
      exp_t e;
      bit   ok;
      pend = 1'b0; bcnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend = 1'b0;
         end else if (pend) begin
            if (bus.busy) begin
               bcnt++;
               if (bcnt > 600) begin
                  errors++; checks++;
                  $display("FAIL busy_timeout: busy for %0d cycles, limit 600", bcnt);
                  if (sbq.size() != 0) void'(sbq.pop_front());
                  pend = 1'b0; done_cnt++;
               end
            end else begin
               if (sbq.size() == 0) begin
                  errors++; checks++;
                  $display("FAIL sb_empty: response seen, 0 expected entries");
               end else begin
                  e = sbq.pop_front();
                  chk("pos_num", bus.pos_num, e.pos);
                  chk("len", 160'(bus.len), 160'(e.len));
                  chk("score", 160'(bus.score), 160'(e.score));
                  chk("game_over", 160'(bus.game_over), 160'(e.over));
                  checks++;
                  if (bcnt < e.bmin || bcnt > e.bmax) begin
                     errors++;
                     $display("FAIL busy_cycles: got %0d required %0d..%0d",
                              bcnt, e.bmin, e.bmax);
                  end
                  if (e.food_known) begin
                     chk("food_pos", 160'(bus.food_pos), 160'(e.food));
                  end else begin
                     ok = (bus.food_pos < 768) && (bus.food_pos != 0);
                     for (int i = 0; i < e.len; i++)
                        if (e.pos[i*10 +: 10] == bus.food_pos) ok = 1'b0;
                     checks++;
                     if (!ok) begin
                        errors++;
                        $display("FAIL food_legal: got %0d required <768 and off body",
                                 bus.food_pos);
                     end
                     m_food = int'(bus.food_pos);
                  end
               end
               pend = 1'b0; done_cnt++;
            end
         end else if (bus.tick || bus.start || probe) begin
            pend = 1'b1; bcnt = 0;
         end
      end
   end

   task automatic wait_done();
      int n;
      n = 0;
      while (done_cnt < issued && n < 1000) begin
         @(posedge clk); n++;
      end
      if (done_cnt < issued) begin
         errors++; checks++;
         $display("FAIL resp_timeout: done %0d required %0d", done_cnt, issued);
         done_cnt = issued;
      end
      repeat (36) @(posedge clk);
   endtask

   task automatic push(input exp_t e);
      sbq.push_back(e);
      issued++;
   endtask

   task automatic do_tick(input bit stop, input int hd, input bit with_start);
      int   n[16];
      int   k, cyc;
      exp_t e;
      n[0] = hd;
      for (int i = 1; i < 16; i++) n[i] = m_pos[i-1];
      if (with_start && m_mode == 0) begin
         m_mode = 1; e = cur_exp();
      end else if (m_mode != 1) begin
         e = cur_exp();
      end else if (stop) begin
         m_mode = 2; e = cur_exp();
      end else begin
         m_pos = n;
         k = 0;
         if (hit_en)
            for (int i = m_len - 1; i >= 1; i--)
               if (n[i] == hd) k = i;
         if (k != 0) begin
            m_mode = 2; e = cur_exp();
            e.bmin = k; e.bmax = k;
         end else begin
            cyc = hit_en ? m_len : 1;
            if (hd == m_food) begin
               if (m_len < 15) m_len++;
               if (m_score < 255) m_score++;
               e = cur_exp();
               e.food_known = 1'b0;
               e.bmin = cyc + m_len + 1; e.bmax = cyc + 500;
            end else begin
               e = cur_exp();
               e.bmin = cyc; e.bmax = cyc;
            end
         end
      end
      push(e);
      @(posedge clk); #1;
      bus.tick = 1'b1; bus.should_stop = stop;
      bus.next_pos_num = pack(n); bus.start = with_start;
      @(posedge clk); #1;
      bus.tick = 1'b0; bus.start = 1'b0; bus.should_stop = 1'b0;
      wait_done();
   endtask

   task automatic do_start();
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 2) model_reset();
      push(cur_exp());
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      wait_done();
   endtask

   task automatic do_probe();
      push(cur_exp());
      @(posedge clk); #1 probe = 1'b1;
      @(posedge clk); #1 probe = 1'b0;
      wait_done();
   endtask

   function automatic int rand_move(input int h);
      int r, c;
      r = h / 32; c = h % 32;
      case ($urandom_range(0, 3))
         0: c = (c + 1) % 32;
         1: c = (c + 31) % 32;
         2: r = (r + 1) % 24;
         default: r = (r + 23) % 24;
      endcase
      return r * 32 + c;
   endfunction

   task automatic reset_abort_food();
      int n[16];
      logic [159:0] rp;
      n[0] = m_food;
      for (int i = 1; i < 16; i++) n[i] = m_pos[i-1];
      @(posedge clk); #1;
      bus.tick = 1'b1; bus.next_pos_num = pack(n);
      @(posedge clk); #1 bus.tick = 1'b0;
      repeat (6) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      rp = pack(m_pos);
      chk("rst_pos", bus.pos_num, rp);
      chk("rst_busy", 160'(bus.busy), 160'(0));
      chk("rst_len", 160'(bus.len), 160'(4));
      chk("rst_food", 160'(bus.food_pos), 160'(180));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      do_probe();
   endtask

   initial begin
      int r;
`ifdef SNAKE_SELF_HIT_EN
      hit_en = 1'b1;
`else
      hit_en = 1'b0;
`endif
      bus.tick = 1'b0; bus.start = 1'b0; bus.should_stop = 1'b0;
      bus.next_pos_num = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      do_probe();                       // reset state
      do_tick(1'b0, 166, 1'b0);         // ignored in IDLE
      do_tick(1'b0, 166, 1'b1);         // start wins, no move
      do_start();                       // ignored in RUN
      do_tick(1'b0, 166, 1'b0);         // plain move
      do_tick(1'b0, m_food, 1'b0);      // eat
      do_tick(1'b1, rand_move(m_pos[0]), 1'b0); // wall
      do_tick(1'b0, 170, 1'b0);         // ignored in OVER
      do_start();                       // OVER -> IDLE reinit
      do_start();                       // IDLE -> RUN
      do_tick(1'b0, m_pos[2], 1'b0);    // head onto slot 3
      if (m_mode == 2) begin
         do_start(); do_start();
      end
      reset_abort_food();
      do_start();
      do_tick(1'b0, 166, 1'b0);

      for (int it = 0; it < 70; it++) begin
         if (m_mode != 1) begin
            do_start();
         end else begin
            r = $urandom_range(0, 99);
            if (r < 4) do_tick(1'b1, rand_move(m_pos[0]), 1'b0);
            else if (r < 7) do_start();
            else if (r < 35) do_tick(1'b0, m_food, 1'b0);
            else do_tick(1'b0, rand_move(m_pos[0]), 1'b0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
